// File: rtl/spi_aes_master.sv
// SPI initiator for the serial AES link: one write frame (message then key, LSB-first),
// an inter-frame gap, then a 129-pulse read frame returning the processed 128-bit block.
module spi_aes_master #(
    parameter int Nk         = 4,
    parameter int CLK_DIV    = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         message_in,
    input  logic [Nk*32-1:0]     key_in,
    output logic                 busy,
    output logic                 done,
    output logic [127:0]         processed_out,
    output logic                 cs,
    output logic                 sclk,
    output logic                 miso,
    input  logic                 mosi
);

    localparam int N  = 128 + Nk * 32;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [8:0]    TX_LAST  = 9'(N - 1);
    localparam logic [8:0]    RX_LAST  = 9'd128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX   = 3'd1,
        GAP  = 3'd2,
        RX   = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t         state_r;
    logic [N-1:0]   tx_shift_r;
    logic [127:0]   rx_shift_r;
    logic [8:0]     bit_cnt_r;
    logic [DW-1:0]  div_cnt_r;
    logic [GW-1:0]  gap_cnt_r;
    logic           div_end_s;

    // Marks the last clk cycle of the current sclk half-period.
    always_comb begin
        div_end_s = (div_cnt_r == DIV_LAST);
    end

    // Transaction sequencer: framing, serial shifting and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            tx_shift_r    <= '0;
            rx_shift_r    <= 128'd0;
            bit_cnt_r     <= 9'd0;
            div_cnt_r     <= '0;
            gap_cnt_r     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            processed_out <= 128'd0;
            cs            <= 1'b0;
            sclk          <= 1'b0;
            miso          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        tx_shift_r <= {key_in, message_in};
                        miso       <= message_in[0];
                        cs         <= 1'b1;
                        sclk       <= 1'b0;
                        busy       <= 1'b1;
                        bit_cnt_r  <= 9'd0;
                        div_cnt_r  <= '0;
                        state_r    <= TX;
                    end
                end
                TX: begin
                    if (div_end_s) begin
                        div_cnt_r <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_cnt_r == TX_LAST) begin
                            cs        <= 1'b0;
                            sclk      <= 1'b0;
                            miso      <= 1'b0;
                            gap_cnt_r <= '0;
                            state_r   <= GAP;
                        end else begin
                            // Next bit is presented together with the falling edge.
                            bit_cnt_r  <= bit_cnt_r + 9'd1;
                            sclk       <= 1'b0;
                            tx_shift_r <= tx_shift_r >> 1;
                            miso       <= tx_shift_r[1];
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        cs        <= 1'b1;
                        sclk      <= 1'b0;
                        bit_cnt_r <= 9'd0;
                        div_cnt_r <= '0;
                        state_r   <= RX;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                RX: begin
                    if (div_end_s) begin
                        div_cnt_r <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Pulse 0 carries no data; later pulses shift in LSB-first.
                            if (bit_cnt_r != 9'd0) begin
                                rx_shift_r <= {mosi, rx_shift_r[127:1]};
                            end
                            if (bit_cnt_r == RX_LAST) begin
                                cs            <= 1'b0;
                                sclk          <= 1'b0;
                                processed_out <= {mosi, rx_shift_r[127:1]};
                                done          <= 1'b1;
                                state_r       <= FIN;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 9'd1;
                                sclk      <= 1'b0;
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cs      <= 1'b0;
                    sclk    <= 1'b0;
                    miso    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_master.sv
// Directed bench for spi_aes_master: two instances (Nk=4/CLK_DIV=1/GAP=2 and
// Nk=8/CLK_DIV=3/GAP=1) with a behavioural peripheral and framing monitor.
module tb_spi_aes_master;

    logic         clk;
    logic         rst;
    logic [1:0]   start;
    logic [127:0] message_in;
    logic [255:0] key_in;
    logic [1:0]   busy, done, cs, sclk, miso, mosi;
    logic [127:0] po [2];

    logic [1:0]   clr;
    logic [127:0] resp [2];
    logic [383:0] tx_bits [2];
    logic [1:0]   p_sclk, p_cs;
    int cyc[2], tx_rises[2], rx_rises[2], rx_falls[2], frames[2];
    int gap_len[2], done_cnt[2], done_cyc[2], frame_err[2], edges[2];

    int compared   = 0;
    int mismatched = 0;

    spi_aes_master #(.Nk(4), .CLK_DIV(1), .GAP_CYCLES(2)) u4 (
        .clk(clk), .rst(rst), .start(start[0]), .message_in(message_in),
        .key_in(key_in[127:0]), .busy(busy[0]), .done(done[0]),
        .processed_out(po[0]), .cs(cs[0]), .sclk(sclk[0]), .miso(miso[0]),
        .mosi(mosi[0])
    );

    spi_aes_master #(.Nk(8), .CLK_DIV(3), .GAP_CYCLES(1)) u8 (
        .clk(clk), .rst(rst), .start(start[1]), .message_in(message_in),
        .key_in(key_in), .busy(busy[1]), .done(done[1]),
        .processed_out(po[1]), .cs(cs[1]), .sclk(sclk[1]), .miso(miso[1]),
        .mosi(mosi[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr[k]) begin
                cyc[k] = 0; tx_rises[k] = 0; rx_rises[k] = 0; rx_falls[k] = 0;
                frames[k] = 0; gap_len[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
                frame_err[k] = 0; edges[k] = 0; tx_bits[k] = '0; mosi[k] = 1'b0;
            end else begin
                cyc[k]++;
                if (cs[k] && !p_cs[k]) frames[k]++;
                if (sclk[k] && !p_sclk[k]) begin
                    edges[k]++;
                    if (!(cs[k] && p_cs[k])) frame_err[k]++;
                    if (frames[k] == 1) begin
                        if (tx_rises[k] < 384) tx_bits[k][tx_rises[k]] = miso[k];
                        tx_rises[k]++;
                    end else begin
                        rx_rises[k]++;
                    end
                end
                if (!sclk[k] && p_sclk[k]) begin
                    edges[k]++;
                    if (!p_cs[k]) frame_err[k]++;
                    if (frames[k] == 2) begin
                        if (rx_falls[k] < 128) mosi[k] = resp[k][rx_falls[k]];
                        rx_falls[k]++;
                    end
                end
                if (busy[k] && !cs[k] && frames[k] == 1) gap_len[k]++;
                if (done[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc[k];
                end
            end
            p_sclk[k] = sclk[k];
            p_cs[k]   = cs[k];
        end
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int k, input logic [127:0] msg, input logic [255:0] key,
                       input logic [127:0] rsp);
        @(posedge clk); #1;
        message_in = msg; key_in = key; resp[k] = rsp;
        start[k] = 1'b1; clr[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0; clr[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        for (int i = 0; i < limit && done_cnt[k] == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] MSG  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY4 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RSP  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY8 =
        256'h8f0e0d0c0b0a09080706050403020100_1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] RSP2 = 128'hdeadbeef_01234567_89abcdef_a5a5c3c3;

    initial begin
        logic [127:0] msg_saved;
        rst = 1'b1; start = 2'b11; clr = 2'b11;
        message_in = MSG; key_in = 256'd0;
        resp[0] = 128'd0; resp[1] = 128'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_busy", {382'd0, busy}, 384'd0);
        end
        chk("rst_outs", {376'd0, cs, sclk, miso, done}, 384'd0);
        chk("rst_po", {128'd0, po[1], po[0]}, 384'd0);
        chk("rst_edges", edges[0] + edges[1], 384'd0);
        rst = 1'b0; start = 2'b00;

        // Basic Nk=4 transaction
        run(0, MSG, {128'd0, KEY4}, RSP);
        wait_done(0, 1000);
        chk("b_first8", {376'd0, tx_bits[0][7:0]}, 384'hff);
        chk("b_txbits", tx_bits[0], {128'd0, KEY4, MSG});
        chk("b_txrises", tx_rises[0], 384'd256);
        chk("b_rxrises", rx_rises[0], 384'd129);
        chk("b_gap", gap_len[0], 384'd2);
        chk("b_frame", frame_err[0], 384'd0);
        chk("b_donecyc", done_cyc[0], 384'd773);
        chk("b_donecnt", done_cnt[0], 384'd1);
        chk("b_result", {256'd0, po[0]}, {256'd0, RSP});
        chk("b_idle", {382'd0, busy[0], cs[0]}, 384'd0);

        // Nk=8, CLK_DIV=3, GAP_CYCLES=1
        run(1, MSG, KEY8, RSP2);
        wait_done(1, 4000);
        chk("k8_txbits", tx_bits[1], {KEY8, MSG});
        chk("k8_lastbit", {383'd0, tx_bits[1][383]}, 384'd1);
        chk("k8_txrises", tx_rises[1], 384'd384);
        chk("k8_rxrises", rx_rises[1], 384'd129);
        chk("k8_gap", gap_len[1], 384'd1);
        chk("k8_frame", frame_err[1], 384'd0);
        chk("k8_donecyc", done_cyc[1], 384'd3080);
        chk("k8_result", {256'd0, po[1]}, {256'd0, RSP2});

        // Abort at TX cycle 100, then a clean transaction
        run(0, ~MSG, {128'd0, KEY4}, RSP2);
        for (int i = 0; i < 300 && cyc[0] < 100; i++) @(posedge clk);
        #1;
        chk("ab_pre", {382'd0, busy[0], cs[0]}, 384'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ab_outs", {381'd0, cs[0], sclk[0], busy[0]}, 384'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("ab_nodone", done_cnt[0], 384'd0);
        run(0, ~MSG, {128'd0, KEY4}, RSP2);
        wait_done(0, 1000);
        chk("ab_txbits", tx_bits[0], {128'd0, KEY4, ~MSG});
        chk("ab_result", {256'd0, po[0]}, {256'd0, RSP2});
        chk("ab_donecyc", done_cyc[0], 384'd773);

        // Start pulses in TX, GAP, RX and FIN; message changed mid-transfer
        msg_saved = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        run(0, msg_saved, {128'd0, KEY4}, RSP);
        for (int c = 1; c <= 780; c++) begin
            start[0] = (c == 50 || c == 513 || c == 600 || c == 773);
            if (c == 50) message_in = ~message_in;
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ig_donecnt", done_cnt[0], 384'd1);
        chk("ig_txbits", tx_bits[0], {128'd0, KEY4, msg_saved});
        chk("ig_frames", frames[0], 384'd2);
        chk("ig_result", {256'd0, po[0]}, {256'd0, RSP});
        chk("ig_idle", {382'd0, busy[0], cs[0]}, 384'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
